// File: rtl/gg_phrase_assembler.sv
// gg_phrase_assembler
//   Builds one bitstream phrase from H.264 syntax elements received one per
//   cycle (U(n), UE, SE, TE, ALIGN, END, END_STOP). Elements are exp-Golomb
//   encoded and packed MSB-first into a right-justified accumulator. A
//   finished phrase is presented together with its bit length, a
//   byte-alignment flag and a sticky error flag.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   in_valid/in_ready      element handshake (in_ready high while accumulating)
//   in_type                0=U 1=UE 2=SE 3=TE 4=ALIGN 5=END 6=END_STOP 7=reserved
//   in_value               element value (SE: two's complement)
//   in_nbits               U: bit count (0 = no-op, >32 clamps to 32 and flags err)
//                          TE: range
//   out_valid/out_ready    phrase handshake
//   out_bits               phrase, right-justified, first element most significant
//   out_len                phrase length in bits
//   out_byte_align         phrase ended on a byte boundary
//   out_err                overflow or illegal element seen in this phrase
//
// Build option
//   GG_PHRASE_TE_EN  when defined, TE uses its range: range 1 emits the single
//                    bit !value[0], range >1 is UE, range 0 is illegal. When
//                    undefined, TE is always UE(value).
module gg_phrase_assembler #(
  parameter int PHRASE_BITS = 1024,
  parameter int VAL_BITS    = 24,
  parameter int LEN_BITS    = $clog2(PHRASE_BITS + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_type,
  input  logic [VAL_BITS-1:0]    in_value,
  input  logic [5:0]             in_nbits,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PHRASE_BITS-1:0] out_bits,
  output logic [LEN_BITS-1:0]    out_len,
  output logic                   out_byte_align,
  output logic                   out_err
);

  // codeNum+1 needs one bit more than the value (SE of the most negative
  // value maps to 2^VAL_BITS).
  localparam int UE_W   = VAL_BITS + 1;
  localparam int CODE_W = (2 * VAL_BITS + 1 > 32) ? 2 * VAL_BITS + 1 : 32;
  localparam int CLEN_W = $clog2(CODE_W + 1);

  typedef enum logic [2:0] {
    T_U        = 3'd0,
    T_UE       = 3'd1,
    T_SE       = 3'd2,
    T_TE       = 3'd3,
    T_ALIGN    = 3'd4,
    T_END      = 3'd5,
    T_END_STOP = 3'd6,
    T_RSV      = 3'd7
  } elem_e;

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_EMIT  = 1'b1
  } state_e;

  // Exp-Golomb length for x = codeNum+1 (x is never zero): 2*floor(log2 x)+1.
  function automatic logic [CLEN_W-1:0] ue_len(input logic [UE_W-1:0] x);
    logic [CLEN_W-1:0] k;
    k = '0;
    for (int i = 0; i < UE_W; i++) begin
      if (x[i]) k = CLEN_W'(i);
    end
    return (k << 1) | CLEN_W'(1);
  endfunction

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [PHRASE_BITS-1:0] r_acc;
  logic [LEN_BITS-1:0]    r_len;
  logic                   r_align;
  logic                   r_err;

  elem_e                  w_type;
  logic [UE_W-1:0]        w_v2;
  logic                   w_se_pos;
  logic [UE_W-1:0]        w_se_cn;
  logic [UE_W-1:0]        w_ue_x;
  logic [UE_W-1:0]        w_se_x;
  logic                   w_u_clamp;
  logic [5:0]             w_u_n;
  logic [31:0]            w_u_val;
  logic [31:0]            w_u_mask;
  logic [2:0]             w_pad;
  logic [2:0]             w_stop_pad;
  logic [CODE_W-1:0]      w_code;
  logic [CLEN_W-1:0]      w_clen;
  logic                   w_bad;
  logic                   w_end;
  logic [LEN_BITS:0]      w_sum;
  logic                   w_fit;
  logic [LEN_BITS-1:0]    w_nlen;

  assign w_type = elem_e'(in_type);

  // SE mapping: v>0 -> 2v-1, else -2v. The doubled value is formed one bit
  // wider so the negation of the most negative input stays exact.
  assign w_v2     = {in_value, 1'b0};
  assign w_se_pos = !in_value[VAL_BITS-1] && (in_value != '0);
  assign w_se_cn  = w_se_pos ? (w_v2 - UE_W'(1)) : (UE_W'(0) - w_v2);
  assign w_ue_x   = {1'b0, in_value} + UE_W'(1);
  assign w_se_x   = w_se_cn + UE_W'(1);

  assign w_u_clamp = (in_nbits > 6'd32);
  assign w_u_n     = w_u_clamp ? 6'd32 : in_nbits;
  assign w_u_val   = 32'(in_value);

  always_comb begin
    w_u_mask = '0;
    for (int i = 0; i < 32; i++) begin
      w_u_mask[i] = (6'(i) < w_u_n);
    end
  end

  // Zero bits needed to reach a byte boundary, and the padding left after a
  // stop bit (which is the bitwise complement of the low length bits).
  assign w_pad      = 3'd0 - r_len[2:0];
  assign w_stop_pad = ~r_len[2:0];

  always_comb begin
    w_code = '0;
    w_clen = '0;
    w_bad  = 1'b0;
    w_end  = 1'b0;
    unique case (w_type)
      T_U: begin
        w_code = CODE_W'(w_u_val & w_u_mask);
        w_clen = CLEN_W'(w_u_n);
        w_bad  = w_u_clamp;
      end
      T_UE: begin
        w_code = CODE_W'(w_ue_x);
        w_clen = ue_len(w_ue_x);
      end
      T_SE: begin
        w_code = CODE_W'(w_se_x);
        w_clen = ue_len(w_se_x);
      end
      T_TE: begin
`ifdef GG_PHRASE_TE_EN
        if (in_nbits == 6'd0) begin
          w_bad = 1'b1;
        end else if (in_nbits == 6'd1) begin
          w_code = CODE_W'(!in_value[0]);
          w_clen = CLEN_W'(1);
        end else begin
          w_code = CODE_W'(w_ue_x);
          w_clen = ue_len(w_ue_x);
        end
`else
        w_code = CODE_W'(w_ue_x);
        w_clen = ue_len(w_ue_x);
`endif
      end
      T_ALIGN: begin
        w_clen = CLEN_W'(w_pad);
      end
      T_END: begin
        w_end = 1'b1;
      end
      T_END_STOP: begin
        w_end  = 1'b1;
        w_code = CODE_W'(1) << w_stop_pad;
        w_clen = CLEN_W'(w_stop_pad) + CLEN_W'(1);
      end
      default: begin
        w_bad = 1'b1;
      end
    endcase
  end

  // An element that would spill past the accumulator is dropped whole.
  assign w_sum  = {1'b0, r_len} + (LEN_BITS + 1)'(w_clen);
  assign w_fit  = (w_sum <= (LEN_BITS + 1)'(PHRASE_BITS));
  assign w_nlen = w_fit ? w_sum[LEN_BITS-1:0] : r_len;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && w_end) w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_ACCUM;
      end
      default: w_state_nxt = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc   <= '0;
      r_len   <= '0;
      r_align <= 1'b0;
      r_err   <= 1'b0;
    end else if (r_state == S_EMIT) begin
      if (out_ready) begin
        r_acc   <= '0;
        r_len   <= '0;
        r_align <= 1'b0;
        r_err   <= 1'b0;
      end
    end else if (in_valid) begin
      if (w_fit) begin
        r_acc <= (r_acc << w_clen) | PHRASE_BITS'(w_code);
        r_len <= w_nlen;
      end
      if (w_bad || !w_fit) r_err <= 1'b1;
      // Alignment is judged on the length the phrase ends with.
      if (w_end) r_align <= (w_nlen[2:0] == 3'd0);
    end
  end

  assign out_bits       = r_acc;
  assign out_len        = r_len;
  assign out_byte_align = r_align;
  assign out_err        = r_err;

endmodule

// File: tb/tb_gg_phrase_assembler.sv
module tb_gg_phrase_assembler;

  localparam int PB = 1024;
  localparam int VB = 24;
  localparam int LB = 11;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_type;
  logic [VB-1:0] in_value;
  logic [5:0]    in_nbits;
  logic          out_valid;
  logic          out_ready;
  logic [PB-1:0] out_bits;
  logic [LB-1:0] out_len;
  logic          out_byte_align;
  logic          out_err;

  always #5 clk = ~clk;

  gg_phrase_assembler #(.PHRASE_BITS(PB), .VAL_BITS(VB), .LEN_BITS(LB)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_value(in_value), .in_nbits(in_nbits),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .out_len(out_len), .out_byte_align(out_byte_align), .out_err(out_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_bits(input string nm, input logic [PB-1:0] act, input logic [PB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got hi64=%h lo64=%h, expected hi64=%h lo64=%h", nm,
               act[PB-1:PB-64], act[63:0], exp[PB-1:PB-64], exp[63:0]);
    end
  endtask

  // Reference model: the phrase is a plain queue of bits, first bit first.
  bit mq[$];
  bit eq[$];
  bit merr;
  bit malign;

  task automatic model_clear();
    mq.delete();
    merr   = 1'b0;
    malign = 1'b0;
  endtask

  task automatic push_ue(input longint cn);
    longint x;
    int nb;
    x  = cn + 1;
    nb = 0;
    for (longint t = x; t > 0; t = t >> 1) nb++;
    repeat (nb - 1) eq.push_back(1'b0);
    for (int i = nb - 1; i >= 0; i--) eq.push_back(x[i]);
  endtask

  task automatic model_elem(input logic [2:0] t, input logic [VB-1:0] v, input logic [5:0] n);
    logic [31:0] v32;
    longint sv;
    int nb;
    eq.delete();
    v32 = 32'(v);
    case (t)
      3'd0: begin
        nb = int'(n);
        if (nb > 32) begin nb = 32; merr = 1'b1; end
        for (int i = nb - 1; i >= 0; i--) eq.push_back(v32[i]);
      end
      3'd1: push_ue(longint'(v));
      3'd2: begin
        sv = longint'($signed(v));
        push_ue(sv > 0 ? 2 * sv - 1 : -2 * sv);
      end
      3'd3: begin
`ifdef GG_PHRASE_TE_EN
        if (n == 6'd0) merr = 1'b1;
        else if (n == 6'd1) eq.push_back(!v[0]);
        else push_ue(longint'(v));
`else
        push_ue(longint'(v));
`endif
      end
      3'd4: while ((mq.size() + eq.size()) % 8 != 0) eq.push_back(1'b0);
      3'd6: begin
        eq.push_back(1'b1);
        while ((mq.size() + eq.size()) % 8 != 0) eq.push_back(1'b0);
      end
      3'd7: merr = 1'b1;
      default: ;
    endcase
    if (mq.size() + eq.size() > PB) merr = 1'b1;
    else foreach (eq[i]) mq.push_back(eq[i]);
    if (t == 3'd5 || t == 3'd6) malign = (mq.size() % 8 == 0);
  endtask

  function automatic logic [PB-1:0] model_bits();
    logic [PB-1:0] r;
    r = '0;
    foreach (mq[i]) r = {r[PB-2:0], mq[i]};
    return r;
  endfunction

  task automatic send(input logic [2:0] t, input logic [VB-1:0] v, input logic [5:0] n);
    int g;
    @(negedge clk);
    in_type = t; in_value = v; in_nbits = n; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 20) begin @(negedge clk); g++; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_ready: in_ready got 0, expected 1");
    end
    @(posedge clk);
    if (in_ready) model_elem(t, v, n);
    #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the edge that accepted END/END_STOP.
  task automatic expect_phrase(input string nm);
    check({nm, " valid"}, out_valid, 1);
    check({nm, " len"}, out_len, mq.size());
    check_bits({nm, " bits"}, out_bits, model_bits());
    check({nm, " align"}, out_byte_align, malign);
    check({nm, " err"}, out_err, merr);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({nm, " in_ready after"}, in_ready, 1);
    check({nm, " valid after"}, out_valid, 0);
    check({nm, " len after"}, out_len, 0);
    check({nm, " err after"}, out_err, 0);
    model_clear();
  endtask

  typedef struct {
    logic [2:0]    t;
    logic [VB-1:0] v;
    logic [5:0]    n;
    logic [63:0]   code;
    int            len;
    bit            err;
  } vec_t;

  vec_t tbl[$];

  task automatic rand_elem();
    int sel;
    logic [2:0] t;
    logic [VB-1:0] v;
    logic [5:0] n;
    sel = $urandom_range(0, 9);
    v   = ($urandom_range(0, 3) == 0) ? VB'($urandom) : VB'($urandom_range(0, 20));
    n   = 6'd0;
    case (sel)
      0, 1: begin t = 3'd0; v = VB'($urandom); n = 6'($urandom_range(0, 34)); end
      2, 3, 9: t = 3'd1;
      4, 5: begin t = 3'd2; if ($urandom_range(0, 1) == 1) v = VB'(0) - v; end
      6: begin t = 3'd3; n = 6'($urandom_range(0, 4)); end
      7: t = 3'd4;
      default: t = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'd1;
    endcase
    send(t, v, n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] eg_exp;
    int ne;

    reset_n = 1'b0; in_valid = 1'b0; in_type = '0; in_value = '0; in_nbits = '0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset out_len", out_len, 0);
    check_bits("reset out_bits", out_bits, '0);
    check("reset out_err", out_err, 0);
    check("reset out_byte_align", out_byte_align, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset in_ready", in_ready, 1);

    // Single-element encodings.
    tbl.push_back(vec_t'{3'd0, 24'h21,     6'd8,  64'h21,       8,  1'b0});
    tbl.push_back(vec_t'{3'd0, 24'hF3,     6'd4,  64'h3,        4,  1'b0});
    tbl.push_back(vec_t'{3'd0, 24'h5,      6'd0,  64'h0,        0,  1'b0});
    tbl.push_back(vec_t'{3'd0, 24'hABCDEF, 6'd40, 64'hABCDEF,   32, 1'b1});
    tbl.push_back(vec_t'{3'd1, 24'd0,      6'd0,  64'h1,        1,  1'b0});
    tbl.push_back(vec_t'{3'd1, 24'd1,      6'd0,  64'h2,        3,  1'b0});
    tbl.push_back(vec_t'{3'd1, 24'd2,      6'd0,  64'h3,        3,  1'b0});
    tbl.push_back(vec_t'{3'd1, 24'd3,      6'd0,  64'h4,        5,  1'b0});
    tbl.push_back(vec_t'{3'd1, 24'd7,      6'd0,  64'h8,        7,  1'b0});
    tbl.push_back(vec_t'{3'd1, 24'hFFFFFF, 6'd0,  64'h1000000,  49, 1'b0});
    tbl.push_back(vec_t'{3'd2, 24'd1,      6'd0,  64'h2,        3,  1'b0});
    tbl.push_back(vec_t'{3'd2, 24'hFFFFFF, 6'd0,  64'h3,        3,  1'b0});
    tbl.push_back(vec_t'{3'd2, 24'd2,      6'd0,  64'h4,        5,  1'b0});
    tbl.push_back(vec_t'{3'd2, 24'hFFFFFE, 6'd0,  64'h5,        5,  1'b0});
    tbl.push_back(vec_t'{3'd2, 24'h800000, 6'd0,  64'h1000001,  49, 1'b0});
    tbl.push_back(vec_t'{3'd3, 24'd2,      6'd3,  64'h3,        3,  1'b0});
    tbl.push_back(vec_t'{3'd3, 24'd0,      6'd1,  64'h1,        1,  1'b0});
`ifdef GG_PHRASE_TE_EN
    tbl.push_back(vec_t'{3'd3, 24'd1,      6'd1,  64'h0,        1,  1'b0});
    tbl.push_back(vec_t'{3'd3, 24'd5,      6'd0,  64'h0,        0,  1'b1});
`else
    tbl.push_back(vec_t'{3'd3, 24'd1,      6'd1,  64'h2,        3,  1'b0});
    tbl.push_back(vec_t'{3'd3, 24'd5,      6'd0,  64'h6,        5,  1'b0});
`endif
    tbl.push_back(vec_t'{3'd4, 24'd0,      6'd0,  64'h0,        0,  1'b0});
    tbl.push_back(vec_t'{3'd7, 24'd9,      6'd3,  64'h0,        0,  1'b1});
    tbl.push_back(vec_t'{3'd6, 24'd0,      6'd0,  64'h80,       8,  1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i].t, tbl[i].v, tbl[i].n);
      if (tbl[i].t != 3'd6) send(3'd5, '0, '0);
      check_bits($sformatf("tbl[%0d] bits", i), out_bits, PB'(tbl[i].code));
      check($sformatf("tbl[%0d] len", i), out_len, tbl[i].len);
      check($sformatf("tbl[%0d] err", i), out_err, tbl[i].err);
      check($sformatf("tbl[%0d] align", i), out_byte_align, (tbl[i].len % 8) == 0);
      expect_phrase($sformatf("tbl[%0d]", i));
    end

    // Skip-style header ending with a stop bit.
    send(3'd0, 24'h21, 6'd8);
    send(3'd1, 24'd0, 6'd0);
    send(3'd1, 24'd0, 6'd0);
    send(3'd1, 24'd0, 6'd0);
    send(3'd6, 24'd0, 6'd0);
    check("skip bits", out_bits[63:0], 64'h21F0);
    check("skip len", out_len, 16);
    check("skip align", out_byte_align, 1);
    expect_phrase("skip");

    // Mixed exp-Golomb phrase.
    send(3'd1, 24'd2, 6'd0);
    send(3'd2, 24'hFFFFFF, 6'd0);
    send(3'd2, 24'd1, 6'd0);
    send(3'd1, 24'd8160, 6'd0);
    send(3'd5, 24'd0, 6'd0);
    eg_exp = 64'({3'b011, 3'b011, 3'b010, 25'd8161});
    check("eg bits", out_bits[63:0], eg_exp);
    check("eg len", out_len, 34);
    check("eg align", out_byte_align, 0);
    expect_phrase("eg");

    // Fill to exactly full, then one element too many.
    repeat (32) send(3'd0, 24'hA5A5A5, 6'd32);
    send(3'd0, 24'h123456, 6'd32);
    send(3'd5, 24'd0, 6'd0);
    check("ovf len", out_len, 1024);
    check("ovf err", out_err, 1);
    check("ovf last word", out_bits[31:0], 32'h00A5A5A5);
    expect_phrase("ovf");
    send(3'd1, 24'd0, 6'd0);
    send(3'd5, 24'd0, 6'd0);
    check("after ovf err", out_err, 0);
    expect_phrase("after ovf");

    // Backpressure: held in EMIT, an offered element must be ignored.
    send(3'd1, 24'd5, 6'd0);
    send(3'd5, 24'd0, 6'd0);
    @(negedge clk);
    in_type = 3'd0; in_value = 24'hFF; in_nbits = 6'd8; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp in_ready c%0d", c), in_ready, 0);
      check($sformatf("bp valid c%0d", c), out_valid, 1);
      check($sformatf("bp len c%0d", c), out_len, 5);
      check($sformatf("bp bits c%0d", c), out_bits[63:0], 64'h6);
    end
    in_valid = 1'b0;
    expect_phrase("bp");
    send(3'd1, 24'd0, 6'd0);
    send(3'd5, 24'd0, 6'd0);
    check("bp next bits", out_bits[63:0], 64'h1);
    check("bp next len", out_len, 1);
    expect_phrase("bp next");

    // Asynchronous reset while a phrase is waiting.
    send(3'd0, 24'hFF, 6'd8);
    send(3'd5, 24'd0, 6'd0);
    check("rst pre valid", out_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst async valid", out_valid, 0);
    check("rst async len", out_len, 0);
    check_bits("rst async bits", out_bits, '0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst after ready c%0d", c), in_ready, 1);
      check($sformatf("rst after valid c%0d", c), out_valid, 0);
    end
    send(3'd1, 24'd2, 6'd0);
    send(3'd5, 24'd0, 6'd0);
    check("rst next bits", out_bits[63:0], 64'h3);
    expect_phrase("rst next");

    // Random phrases against the bit-queue model.
    for (int p = 0; p < 40; p++) begin
      ne = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 45) : $urandom_range(1, 12);
      for (int e = 0; e < ne; e++) rand_elem();
      send(($urandom_range(0, 1) == 1) ? 3'd6 : 3'd5, '0, '0);
      expect_phrase($sformatf("rand%0d", p));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
